// File: rtl/wb_regfile_writer.sv
// Writeback stage: selects the writeback value, commits it to a 16x16 register
// file, serves two decode read ports with write-to-read bypass, and keeps a
// registered commit trace, commit counter and sticky out-of-range flag.
module wb_regfile_writer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              wb_fire,
    input  logic              wb_regwrite,
    input  logic              wb_regstore,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [15:0]       wb_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [15:0]       commit_count,
    output logic              rd_range_err
);

    localparam int unsigned RD_W  = 16;
    localparam int unsigned CNT_W = 16;

    logic [DATA_W-1:0] regs_q [NREGS];

    logic              commit_valid_q, commit_valid_d;
    logic [ADDR_W-1:0] commit_rd_q,    commit_rd_d;
    logic [DATA_W-1:0] commit_data_q,  commit_data_d;
    logic [CNT_W-1:0]  commit_count_q, commit_count_d;
    logic              rd_range_err_q, rd_range_err_d;

    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] rd_idx;
    logic              wr_req;
    logic              rd_in_range;
    logic              wr_ok;

    // Writeback value select and write qualification; r0 and out-of-range targets never write.
    always_comb begin
        wdata       = wb_regstore ? wb_mem_data : wb_alu_result;
        rd_idx      = wb_rd[ADDR_W-1:0];
        wr_req      = wb_fire & wb_regwrite;
        rd_in_range = (wb_rd[RD_W-1:ADDR_W] == '0);
        wr_ok       = wr_req & rd_in_range & (rd_idx != '0);
    end

    // Register file storage; entry 0 is never written so it stays zero.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[rd_idx] <= wdata;
        end
    end

    // Read ports: r0 reads zero, a same-cycle write to the named register is bypassed.
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wr_ok && (rs1_addr == rd_idx)) begin
            rs1_data = wdata;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wr_ok && (rs2_addr == rd_idx)) begin
            rs2_data = wdata;
        end
    end

    // Next commit trace: in-range requests commit (r0 reports data 0), others hold.
    always_comb begin
        commit_valid_d = wr_req & rd_in_range;
        commit_rd_d    = commit_rd_q;
        commit_data_d  = commit_data_q;
        commit_count_d = commit_count_q;
        rd_range_err_d = rd_range_err_q | (wr_req & ~rd_in_range);
        if (commit_valid_d) begin
            commit_rd_d    = rd_idx;
            commit_data_d  = (rd_idx == '0) ? '0 : wdata;
            commit_count_d = CNT_W'(commit_count_q + CNT_W'(1));
        end
    end

    // Commit trace, counter and sticky error registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
            commit_count_q <= '0;
            rd_range_err_q <= 1'b0;
        end else begin
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_data_q  <= commit_data_d;
            commit_count_q <= commit_count_d;
            rd_range_err_q <= rd_range_err_d;
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_rd    = commit_rd_q;
    assign commit_data  = commit_data_q;
    assign commit_count = commit_count_q;
    assign rd_range_err = rd_range_err_q;

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Randomized bench for wb_regfile_writer: reference model of the register file
// and commit counter, commit trace checked from a scoreboard queue.
module tb_wb_regfile_writer;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] data;
    } commit_t;

    logic        CLK;
    logic        Reset;
    logic        wb_fire;
    logic        wb_regwrite;
    logic        wb_regstore;
    logic [15:0] wb_alu_result;
    logic [15:0] wb_mem_data;
    logic [15:0] wb_rd;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic        commit_valid;
    logic [3:0]  commit_rd;
    logic [15:0] commit_data;
    logic [15:0] commit_count;
    logic        rd_range_err;

    wb_regfile_writer #(.DATA_W(16), .NREGS(16), .ADDR_W(4)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .wb_fire      (wb_fire),
        .wb_regwrite  (wb_regwrite),
        .wb_regstore  (wb_regstore),
        .wb_alu_result(wb_alu_result),
        .wb_mem_data  (wb_mem_data),
        .wb_rd        (wb_rd),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .commit_count (commit_count),
        .rd_range_err (rd_range_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model state.
    logic [15:0] m_regs [16];
    logic [15:0] m_cnt;
    logic        m_err;
    commit_t     exp_q [$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] a, input logic ok,
                                               input logic [3:0] idx, input logic [15:0] wd);
        if (a == 4'd0) return 16'h0000;
        if (ok && a == idx) return wd;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_cnt = 16'h0000;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    // One clock of stimulus: drive, check read ports, then advance the model at the edge.
    task automatic cyc(input logic f, input logic rw, input logic rs,
                       input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] rd,
                       input logic [3:0] a1, input logic [3:0] a2);
        logic [15:0] wd;
        logic [3:0]  idx;
        logic        inr;
        logic        ok;
        wb_fire = f; wb_regwrite = rw; wb_regstore = rs;
        wb_alu_result = alu; wb_mem_data = mem; wb_rd = rd;
        rs1_addr = a1; rs2_addr = a2;
        wd  = rs ? mem : alu;
        idx = rd[3:0];
        inr = (rd[15:4] == 12'h000);
        ok  = f & rw & inr & (idx != 4'd0);
        #1;
        chk("rs1_data", 32'(rs1_data), 32'(model_read(a1, ok, idx, wd)));
        chk("rs2_data", 32'(rs2_data), 32'(model_read(a2, ok, idx, wd)));
        @(posedge CLK);
        if (f && rw) begin
            if (inr) begin
                if (idx != 4'd0) m_regs[idx] = wd;
                m_cnt = m_cnt + 16'd1;
                exp_q.push_back('{rd: idx, data: (idx != 4'd0) ? wd : 16'h0000});
            end else begin
                m_err = 1'b1;
            end
        end
        #2;
    endtask

    task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, a1, a2);
    endtask

    // Monitor: after every edge, compare the commit trace against the scoreboard.
    initial begin
        commit_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (!Reset) begin
                if (commit_valid) begin
                    chk("commit_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("commit_rd", 32'(commit_rd), 32'(e.rd));
                        chk("commit_data", 32'(commit_data), 32'(e.data));
                    end
                end else begin
                    chk("commit_missing", 32'(exp_q.size()), 32'd0);
                    exp_q.delete();
                end
                chk("commit_count", 32'(commit_count), 32'(m_cnt));
                chk("rd_range_err", 32'(rd_range_err), 32'(m_err));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_commit_valid"}, 32'(commit_valid), 32'd0);
        chk({tag, "_commit_rd"},    32'(commit_rd),    32'd0);
        chk({tag, "_commit_data"},  32'(commit_data),  32'd0);
        chk({tag, "_commit_count"}, 32'(commit_count), 32'd0);
        chk({tag, "_rd_range_err"}, 32'(rd_range_err), 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] cnt0;
        logic [3:0]  a1;
        logic [3:0]  a2;
        Reset = 1'b0;
        wb_fire = 1'b0; wb_regwrite = 1'b0; wb_regstore = 1'b0;
        wb_alu_result = '0; wb_mem_data = '0; wb_rd = '0;
        rs1_addr = '0; rs2_addr = '0;
        model_reset();
        #1 Reset = 1'b1;
        #1;
        check_all_zero("por");
        repeat (2) @(posedge CLK);
        #2;
        Reset = 1'b0;

        // Basic ALU write to r3, then read it back.
        cyc(1'b1, 1'b1, 1'b0, 16'h1234, 16'h5555, 16'd3, 4'd0, 4'd3);
        chk("t1_count", 32'(commit_count), 32'd1);
        idle(4'd3, 4'd0);

        // Load-data write to r5 with same-cycle bypass on port 2.
        cyc(1'b1, 1'b1, 1'b1, 16'h0001, 16'hBEEF, 16'd5, 4'd3, 4'd5);
        chk("t2_bypass_seen", 32'(commit_data), 32'h0000BEEF);
        idle(4'd5, 4'd5);

        // Write to r0 is dropped but still commits and counts.
        cyc(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'd0, 4'd0, 4'd0);
        chk("t3_commit_rd0", 32'(commit_valid), 32'd1);
        idle(4'd0, 4'd5);

        // Stalled stage with regwrite held: exactly one commit.
        cnt0 = m_cnt;
        cyc(1'b1, 1'b1, 1'b0, 16'h7777, 16'h0, 16'd7, 4'd7, 4'd7);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 16'h8888, 16'h0, 16'd7, 4'd7, 4'd1);
        chk("t4_one_commit", 32'(commit_count), 32'(cnt0 + 16'd1));

        // Out-of-range destination: no write, no count, sticky error.
        cyc(1'b1, 1'b1, 1'b0, 16'hDEAD, 16'h0, 16'h0012, 4'd2, 4'd3);
        chk("t5_err_set", 32'(rd_range_err), 32'd1);
        repeat (3) idle(4'd2, 4'd3);
        chk("t5_err_sticky", 32'(rd_range_err), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rd = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) rd = 16'($urandom) | 16'h0010;
            a1 = ($urandom_range(0, 3) == 0) ? rd[3:0] : 4'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? rd[3:0] : 4'($urandom);
            cyc(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0), 1'($urandom),
                16'($urandom), 16'($urandom), rd, a1, a2);
        end

        // Drive the counter to 0xFFFF, then one more commit wraps it to zero.
        while (m_cnt != 16'hFFFF) begin
            cyc(1'b1, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom_range(1, 15)), 4'($urandom), 4'($urandom));
        end
        chk("t6_count_ffff", 32'(commit_count), 32'h0000FFFF);
        cyc(1'b1, 1'b1, 1'b0, 16'h4242, 16'h0, 16'd9, 4'd9, 4'd0);
        chk("t6_count_wrap", 32'(commit_count), 32'h00000000);

        // Reset asserted mid-cycle with a write pending: everything clears at once.
        wb_fire = 1'b1; wb_regwrite = 1'b1; wb_regstore = 1'b0;
        wb_alu_result = 16'hA5A5; wb_rd = 16'd4;
        rs1_addr = 4'd9; rs2_addr = 4'd5;
        #1 Reset = 1'b1;
        #1;
        check_all_zero("rst");
        chk("rst_rs1", 32'(rs1_data), 32'd0);
        chk("rst_rs2", 32'(rs2_data), 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        check_all_zero("rst_hold");
        #1;
        Reset = 1'b0;
        idle(4'd4, 4'd9);
        cyc(1'b1, 1'b1, 1'b1, 16'h0, 16'h3C3C, 16'd4, 4'd4, 4'd0);
        chk("post_rst_count", 32'(commit_count), 32'd1);
        idle(4'd4, 4'd4);
        idle(4'd0, 4'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
